// File: rtl/joypad_port_sequencer.sv
// Two-port NES controller sequencer at $4016/$4017: strobe latch, per-port
// load/shift/drained serialiser and a poll-complete pulse for the keyboard front end.
module joypad_port_sequencer #(
   parameter logic [15:0] ADDR_P1  = 16'h4016,
   parameter logic [15:0] ADDR_P2  = 16'h4017,
   parameter logic [7:0]  OPEN_BUS = 8'h40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ENABLE,
   input  logic        WR,
   input  logic [15:0] addr,
   input  logic [7:0]  bus,
   input  logic [7:0]  pad1,
   input  logic [7:0]  pad2,
   output logic [7:0]  DATA,
   output logic        strobe,
   output logic        poll_done
);

   localparam int unsigned NPORTS = 2;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(7);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(8);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_SHIFT,
      ST_DRAINED
   } port_state_e;

   port_state_e      state_q [NPORTS];
   port_state_e      state_d [NPORTS];
   logic [7:0]       sr_q    [NPORTS];
   logic [7:0]       sr_d    [NPORTS];
   logic [CNT_W-1:0] cnt_q   [NPORTS];
   logic [CNT_W-1:0] cnt_d   [NPORTS];
   logic [7:0]       pad_c   [NPORTS];
   logic [NPORTS-1:0] rd_hit_c;

   logic [7:0] p1_q, p2_q;
   logic [7:0] data_q, data_d;
   logic       strobe_q, strobe_d;
   logic       poll_done_q, poll_done_d;
   logic       wr_p1_c;
   logic       unused_bus_bits;

   assign unused_bus_bits = ^bus[7:1];

   assign wr_p1_c     = ENABLE && WR && (addr == ADDR_P1);
   assign rd_hit_c[0] = ENABLE && !WR && (addr == ADDR_P1);
   assign rd_hit_c[1] = ENABLE && !WR && (addr == ADDR_P2);
   assign pad_c[0]    = p1_q;
   assign pad_c[1]    = p2_q;

   // State register, pad input stage and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p1_q        <= 8'h00;
         p2_q        <= 8'h00;
         data_q      <= 8'h00;
         strobe_q    <= 1'b0;
         poll_done_q <= 1'b0;
         for (int i = 0; i < NPORTS; i++) begin
            state_q[i] <= ST_SHIFT;
            sr_q[i]    <= 8'h00;
            cnt_q[i]   <= '0;
         end
      end else begin
         p1_q        <= pad1;
         p2_q        <= pad2;
         data_q      <= data_d;
         strobe_q    <= strobe_d;
         poll_done_q <= poll_done_d;
         for (int i = 0; i < NPORTS; i++) begin
            state_q[i] <= state_d[i];
            sr_q[i]    <= sr_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // Next-state: per-port serialiser, read data mux, strobe latch
   always_comb begin : next_state_p
      logic rd_bit;
      strobe_d    = strobe_q;
      data_d      = data_q;
      poll_done_d = 1'b0;
      rd_bit      = 1'b0;
      if (wr_p1_c) strobe_d = bus[0];

      for (int i = 0; i < NPORTS; i++) begin
         state_d[i] = state_q[i];
         sr_d[i]    = sr_q[i];
         cnt_d[i]   = cnt_q[i];
         rd_bit     = 1'b0;

         case (state_q[i])
            ST_LOAD: begin
               // Continuous reload, so the strobe-clear edge keeps the current snapshot
               sr_d[i]  = pad_c[i];
               cnt_d[i] = '0;
               rd_bit   = pad_c[i][7];
               if (wr_p1_c && !bus[0]) state_d[i] = ST_SHIFT;
            end
            ST_SHIFT: begin
               rd_bit = sr_q[i][7];
               if (rd_hit_c[i]) begin
                  sr_d[i]  = {sr_q[i][6:0], 1'b1};
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  if (cnt_q[i] == CNT_LAST) begin
                     state_d[i] = ST_DRAINED;
                     if (i == 0) poll_done_d = 1'b1;
                  end
               end
            end
            ST_DRAINED: begin
               sr_d[i]  = 8'hFF;
               cnt_d[i] = CNT_FULL;
               rd_bit   = 1'b1;
            end
            default: begin
               state_d[i] = ST_SHIFT;
            end
         endcase

         if (wr_p1_c && bus[0]) begin
            state_d[i] = ST_LOAD;
            sr_d[i]    = pad_c[i];
            cnt_d[i]   = '0;
         end

         if (rd_hit_c[i]) data_d = OPEN_BUS | {7'b0, rd_bit};
      end
   end

   assign DATA      = data_q;
   assign strobe    = strobe_q;
   assign poll_done = poll_done_q;

endmodule

// File: tb/tb_joypad_port_sequencer.sv
// Self-checking bench for joypad_port_sequencer: directed table, corner sequences,
// and randomized traffic checked against a per-port bit-index reference model.
module tb_joypad_port_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        en, wr;
   logic [15:0] addr;
   logic [7:0]  bus, pad1, pad2;
   logic [7:0]  data;
   logic        strobe, poll_done;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic       m_strobe;
   logic [7:0] m_p   [2];
   logic [7:0] m_lat [2];
   int         m_cnt [2];
   logic [7:0] m_data;
   logic       m_poll;

   typedef struct {
      logic        en;
      logic        wr;
      logic [15:0] a;
      logic [7:0]  b;
      logic [7:0]  p1;
      logic [7:0]  p2;
      logic        chk;
      logic [7:0]  exp_data;
      logic        exp_poll;
   } vec_t;

   vec_t vecs[$];

   joypad_port_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .ENABLE    (en),
      .WR        (wr),
      .addr      (addr),
      .bus       (bus),
      .pad1      (pad1),
      .pad2      (pad2),
      .DATA      (data),
      .strobe    (strobe),
      .poll_done (poll_done)
   );

   always #5 clk = ~clk;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_strobe = 1'b0;
      m_data   = 8'h00;
      m_poll   = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_p[i]   = 8'h00;
         m_lat[i] = 8'h00;
         m_cnt[i] = 0;
      end
   endtask

   // Model: each port holds a latched byte and a count of bits already delivered
   task automatic model_step();
      int port;
      logic b;
      m_poll = 1'b0;
      if (en && wr && addr == 16'h4016) begin
         if (bus[0]) m_strobe = 1'b1;
         else if (m_strobe) begin
            m_strobe = 1'b0;
            for (int i = 0; i < 2; i++) begin
               m_lat[i] = m_p[i];
               m_cnt[i] = 0;
            end
         end
      end else if (en && !wr && (addr == 16'h4016 || addr == 16'h4017)) begin
         port = (addr == 16'h4016) ? 0 : 1;
         if (m_strobe) b = m_p[port][7];
         else if (m_cnt[port] < 8) begin
            b = m_lat[port][7 - m_cnt[port]];
            m_cnt[port]++;
            if (port == 0 && m_cnt[port] == 8) m_poll = 1'b1;
         end else b = 1'b1;
         m_data = 8'h40 | {7'b0, b};
      end
      m_p[0] = pad1;
      m_p[1] = pad2;
   endtask

   task automatic cycle(input logic e, input logic w, input logic [15:0] a, input logic [7:0] b,
                        input logic [7:0] p1, input logic [7:0] p2);
      en = e; wr = w; addr = a; bus = b; pad1 = p1; pad2 = p2;
      @(posedge clk);
      model_step();
      #1;
      check8("model_data", data, m_data);
      check8("model_strobe", {7'b0, strobe}, {7'b0, m_strobe});
      check8("model_poll", {7'b0, poll_done}, {7'b0, m_poll});
   endtask

   task automatic do_reset();
      en = 1'b0;
      reset = 1'b1;
      #2;
      check8("async_rst_data", data, 8'h00);
      check8("async_rst_strobe", {7'b0, strobe}, 8'h00);
      check8("async_rst_poll", {7'b0, poll_done}, 8'h00);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic vec_t mk(logic e, logic w, logic [15:0] a, logic [7:0] b,
                               logic [7:0] p1, logic [7:0] p2, logic c,
                               logic [7:0] ed, logic ep);
      vec_t v;
      v.en = e; v.wr = w; v.a = a; v.b = b; v.p1 = p1; v.p2 = p2;
      v.chk = c; v.exp_data = ed; v.exp_poll = ep;
      return v;
   endfunction

   initial begin
      logic [7:0] seq1 [8];
      logic [7:0] p1r, p2r;
      int r;
      seq1 = '{8'h41, 8'h40, 8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h41};

      reset = 1'b1; en = 1'b0; wr = 1'b0; addr = 16'h0; bus = 8'h0; pad1 = 8'h0; pad2 = 8'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check8("reset_data", data, 8'h00);
      check8("reset_strobe", {7'b0, strobe}, 8'h00);
      check8("reset_poll", {7'b0, poll_done}, 8'h00);
      reset = 1'b0;

      // Directed table
      vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 8'hA5, 8'h00, 0, 8'h00, 0));
      vecs.push_back(mk(1, 1, 16'h4016, 8'h01, 8'hA5, 8'h00, 0, 8'h00, 0));
      vecs.push_back(mk(1, 1, 16'h4016, 8'h00, 8'hA5, 8'h00, 1, 8'h00, 0));
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(1, 0, 16'h4016, 8'h00, 8'hA5, 8'h00, 1, seq1[i], i == 7));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1, 0, 16'h4016, 8'h00, 8'hA5, 8'h00, 1, 8'h41, 0));
      vecs.push_back(mk(1, 1, 16'h4016, 8'h01, 8'h80, 8'h00, 0, 8'h41, 0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1, 0, 16'h4016, 8'h00, 8'h80, 8'h00, 1, 8'h41, 0));
      vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 8'h41, 0));
      vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 8'h41, 0));
      vecs.push_back(mk(1, 0, 16'h4016, 8'h00, 8'h00, 8'h00, 1, 8'h40, 0));
      vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 8'hFF, 8'h00, 0, 8'h40, 0));
      vecs.push_back(mk(1, 1, 16'h4016, 8'h01, 8'hFF, 8'h00, 0, 8'h40, 0));
      vecs.push_back(mk(1, 1, 16'h4016, 8'h00, 8'hFF, 8'h00, 0, 8'h40, 0));
      vecs.push_back(mk(1, 0, 16'h4017, 8'h00, 8'hFF, 8'h00, 1, 8'h40, 0));
      vecs.push_back(mk(1, 0, 16'h4016, 8'h00, 8'hFF, 8'h00, 1, 8'h41, 0));
      vecs.push_back(mk(1, 0, 16'h4017, 8'h00, 8'hFF, 8'h00, 1, 8'h40, 0));
      vecs.push_back(mk(1, 0, 16'h4016, 8'h00, 8'hFF, 8'h00, 1, 8'h41, 0));

      foreach (vecs[i]) begin
         cycle(vecs[i].en, vecs[i].wr, vecs[i].a, vecs[i].b, vecs[i].p1, vecs[i].p2);
         if (vecs[i].chk) begin
            check8($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            check8($sformatf("vec%0d_poll", i), {7'b0, poll_done}, {7'b0, vecs[i].exp_poll});
         end
      end

      // Pad change on the same clk as the strobe-clear write: old registered value wins
      cycle(0, 0, 16'h0000, 8'h00, 8'h00, 8'h00);
      cycle(1, 1, 16'h4016, 8'h01, 8'h00, 8'h00);
      cycle(0, 0, 16'h0000, 8'h00, 8'h00, 8'h00);
      cycle(1, 1, 16'h4016, 8'h00, 8'h80, 8'h00);
      cycle(1, 0, 16'h4016, 8'h00, 8'h80, 8'h00);
      check8("same_clk_pad", data, 8'h40);

      // Reset partway through a poll sequence
      cycle(1, 1, 16'h4016, 8'h01, 8'hFF, 8'h00);
      cycle(0, 0, 16'h0000, 8'h00, 8'hFF, 8'h00);
      cycle(1, 1, 16'h4016, 8'h00, 8'hFF, 8'h00);
      for (int i = 0; i < 4; i++) cycle(1, 0, 16'h4016, 8'h00, 8'hFF, 8'h00);
      check8("pre_reset_data", data, 8'h41);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(1, 0, 16'h4016, 8'h00, 8'hFF, 8'h00);
         check8($sformatf("post_reset_rd%0d", i), data, 8'h40);
         check8($sformatf("post_reset_poll%0d", i), {7'b0, poll_done}, {7'b0, i == 7});
      end
      cycle(1, 0, 16'h4016, 8'h00, 8'hFF, 8'h00);
      check8("post_reset_rd8", data, 8'h41);

      // Randomized traffic against the model
      p1r = 8'h00; p2r = 8'h00;
      for (int n = 0; n < 3000; n++) begin
         logic [15:0] a;
         if ($urandom_range(0, 3) == 0) p1r = 8'($urandom);
         if ($urandom_range(0, 3) == 0) p2r = 8'($urandom);
         r = $urandom_range(0, 9);
         a = (r < 5) ? 16'h4016 : (r < 8) ? 16'h4017 : 16'($urandom);
         if ($urandom_range(0, 499) == 0) do_reset();
         else cycle(($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0), a,
                    8'($urandom), p1r, p2r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/joypad_port_sequencer.md
# joypad_port_sequencer

Sequences the two NES controller ports at CPU addresses $4016/$4017. It latches keyboard-derived button snapshots on strobe and serialises them one bit per CPU read, with the serial-port semantics games expect. It sits between the CPU bus decode and the keyboard button adapters, replacing the single-port shift path. It also emits a poll-complete pulse so the keyboard front end knows when a frame's read sequence has finished.

## Interface
Parameters:
- ADDR_P1, 16'h4016, strobe write address and port-1 read address
- ADDR_P2, 16'h4017, port-2 read address
- OPEN_BUS, 8'h40, constant OR'd into every read result; bit 0 must be 0

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- ENABLE  in  1  one-clk CPU access qualifier; exactly one pulse per CPU bus cycle
- WR  in  1  1 = write, 0 = read; sampled only when ENABLE=1
- addr  in  16  CPU address; sampled only when ENABLE=1
- bus  in  8  CPU write data
- pad1  in  8  port-1 buttons, active-high: [7]A [6]B [5]Select [4]Start [3]Up [2]Down [1]Left [0]Right
- pad2  in  8  port-2 buttons, same bit order
- DATA  out  8  read result, held until the next qualifying read
- strobe  out  1  current strobe latch (bus[0] of the last $4016 write)
- poll_done  out  1  one-clk pulse when port 1 completes its 8th shifted read

## Operation
- Input stage: pad1 and pad2 are registered every clk into p1_q and p2_q. All loads use the registered copies.
- Strobe write: when ENABLE & WR & addr==ADDR_P1, strobe <= bus[0]. Writes to ADDR_P2 and other addresses are ignored.
- State machine per port, with states LOAD, SHIFT and DRAINED:
  - LOAD (strobe=1): the shift register reloads from p*_q every clk, and the counter is held at 0.
  - LOAD→SHIFT: on the write that clears strobe. The shift register keeps the value loaded on that same clk edge, and the counter is 0.
  - SHIFT: each qualifying read of the port returns sr[7]. Then sr <= {sr[6:0],1'b1} and cnt <= cnt+1.
  - SHIFT→DRAINED: when cnt reaches 8.
  - DRAINED: reads return 1 and sr stays 8'hFF. The counter saturates at 8.
  - Any state→LOAD: a write with bus[0]=1.
- Read in LOAD: returns the live p*_q[7] (A button). There is no shift and the counter is unchanged.
- Read result: DATA <= OPEN_BUS | {7'b0, bit}. Reads to other addresses leave DATA unchanged.
- poll_done: pulses when port 1's counter goes 7→8. It does not pulse on port-2 reads.
- The two ports are independent. Reading one never advances the other.
- Writes never change DATA.

## Timing
- Reset values:
  - DATA=8'h00, strobe=0, poll_done=0.
  - Both shift registers 8'h00, both counters 0, both ports in SHIFT.
  - p1_q and p2_q = 8'h00.
- Pad latency: a pad change is visible to loads 1 clk later. A strobe-clear write captures pad values registered at least 1 clk before the write.
- Read latency: DATA and the shift update on the rising edge that samples ENABLE. DATA is valid the clk after the ENABLE cycle.
- poll_done asserts on the same edge as the 8th read's DATA update and lasts 1 clk.
- ENABLE held high for multiple clks counts as multiple accesses. Deduplication is the bus decoder's job.
- Reset mid-sequence: all state returns to reset values immediately (asynchronous). Reads after reset and before any strobe return OPEN_BUS for 8 reads, then OPEN_BUS|1.

## Test plan
- Reset, then pad1=8'hA5. Write $4016=1, write $4016=0, then 8 reads of $4016. DATA sequence is 41,40,41,40,40,41,40,41. poll_done pulses once, on the 8th read.
- Continue from the above with 3 more reads of $4016. Each returns 8'h41 and poll_done stays 0.
- Set strobe=1 and pad1=8'h80, then read $4016 three times. Each returns 8'h41. Set pad1=8'h00, wait 2 clk, read: returns 8'h40. The counter stays 0 and there is no poll_done.
- Independence: pad1=8'hFF, pad2=8'h00, strobe 1→0. Interleave reads: $4017, $4016, $4017, $4016. Results are 40,41,40,41. Port-2 reads produce no poll_done.
- Pad1 changes from 8'h00 to 8'h80 on the same clk as the strobe-clear write. The first read returns 8'h40, because the old registered value was latched.
- After 4 of 8 reads, assert reset for 1 clk. DATA=00 and strobe=0. The next 8 reads of $4016 return 8'h40, and the 9th returns 8'h41.
